// File: rtl/rs232_pkg.sv
// rs232_pkg: shared RS232 state encoding and frame timing helpers.
package rs232_pkg;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_RECV  = 2'd1;
  localparam rx_state_t ST_BREAK = 2'd2;

  // Mid-bit sample offset of bit k from the start edge; 64-bit to survive large clocks.
  function automatic longint rs232_sample_point(input longint clock_freq,
                                                input longint baud_rate,
                                                input int     k);
    return (clock_freq * (2 * longint'(k) + 1)) / (2 * baud_rate);
  endfunction

  function automatic int rs232_frame_bits(input int data_bits, input bit parity);
    return data_bits + (parity ? 3 : 2);
  endfunction

endpackage

// File: rtl/rs232_fifo.sv
// rs232_fifo: first-word-fall-through FIFO with occupancy count and push-accept flag.
`default_nettype none
module rs232_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     accept,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;

  assign count  = wr_ptr - rd_ptr;
  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  // Depth is a power of two, so the count MSB alone means full.
  assign accept = push & (~count[AW] | do_pop);
  assign head   = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/rs232_recv_fifo.sv
// rs232_recv_fifo: RS232 receiver with receive FIFO and level-based CTS flow control.
// Optional parity checking is enabled by defining RS232_RX_PARITY_EN.
`default_nettype none
module rs232_recv_fifo
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int DEPTH      = 16,
  parameter int CTS_MARGIN = 2,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rs232_txd,
  output logic                 rs232_cts_n,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun
);

`ifdef RS232_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int     FRAME_BITS = rs232_frame_bits(DATA_BITS, PAR_EN);
  localparam int     STOP_IDX   = FRAME_BITS - 1;
  localparam int     PAR_IDX    = DATA_BITS + 1;
  localparam longint STOP_SP    = rs232_sample_point(CLOCK_FREQ, BAUD_RATE, STOP_IDX);
  localparam int     TW         = $clog2(STOP_SP) + 1;
  localparam int     IW         = $clog2(FRAME_BITS);
  localparam int     AW         = $clog2(DEPTH);
  localparam bit     ODD        = (ODD_PARITY != 0);

  logic                 sync1;
  logic                 rxs;
  logic                 rxs_d;
  rx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 hit;
  logic                 at_stop;
  logic                 stop_sample;
  logic                 par_ok;
  logic                 good_word;
  logic                 accept;
  logic                 pop_fire;
  logic [AW:0]          count;
  logic [AW:0]          count_next;
  logic                 par_err_q;
  logic [TW-1:0]        sp_tab [FRAME_BITS];

  for (genvar g = 0; g < FRAME_BITS; g++) begin : g_sp
    assign sp_tab[g] = TW'(rs232_sample_point(CLOCK_FREQ, BAUD_RATE, g));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rs232_txd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign hit         = (state == ST_RECV) && (timer == sp_tab[bit_idx]);
  assign at_stop     = (bit_idx == IW'(STOP_IDX));
  assign stop_sample = hit & at_stop;
  assign par_ok      = !PAR_EN || (((^shreg) ^ ODD) == par_bit);
  assign good_word   = stop_sample & rxs & par_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (rxs_d & ~rxs) state <= ST_RECV;
        end
        ST_RECV: begin
          timer <= timer + 1'b1;
          if (hit) begin
            bit_idx <= bit_idx + 1'b1;
            // A start bit that reads high again was only a glitch.
            if (bit_idx == '0) begin
              if (rxs) state <= ST_IDLE;
            end else if (at_stop) begin
              state <= rxs ? ST_IDLE : ST_BREAK;
            end else if (PAR_EN && (bit_idx == IW'(PAR_IDX))) begin
              par_bit <= rxs;
            end else begin
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
            end
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rs232_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (good_word),
    .push_data (shreg),
    .pop       (ready),
    .head      (data),
    .valid     (valid),
    .accept    (accept),
    .count     (count)
  );

  assign pop_fire   = valid & ready;
  assign count_next = count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop_fire};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_error <= 1'b0;
      par_err_q   <= 1'b0;
      overrun     <= 1'b0;
      rs232_cts_n <= 1'b1;
    end else begin
      frame_error <= stop_sample & ~rxs;
      par_err_q   <= stop_sample & ~par_ok;
      overrun     <= good_word & ~accept;
      rs232_cts_n <= ((AW+1)'(DEPTH) - count_next) <= (AW+1)'(CTS_MARGIN);
    end
  end

  assign parity_error = PAR_EN & par_err_q;

endmodule
`default_nettype wire

// File: doc/rs232_recv_fifo.md
# rs232_recv_fifo

Parametrised RS232 receiver with an integrated receive FIFO and level-based hardware flow control. It is the receive-side counterpart of `rs232_send`. It deserialises 5–9 data bits per frame, validates the start bit, the stop bit and (optionally) parity, and buffers good words for a ready/valid consumer. It sits between the board-level TXD pin and the command parser.

## Interface
Parameters:
- `CLOCK_FREQ`, 133000000: clock frequency in Hz; need not be a multiple of `BAUD_RATE`.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `DEPTH`, 16: FIFO depth in words; power of two, at least 2.
- `CTS_MARGIN`, 2: free-slot threshold for deasserting clear-to-send; range 1 to `DEPTH`-1.
- `ODD_PARITY`, 0: 0 selects even parity, 1 selects odd; only used when `RS232_RX_PARITY_EN` is defined.

Ports:
- `clock`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rs232_txd`  in  1: serial line, idle high; asynchronous to `clock`.
- `rs232_cts_n`  out  1: active-low clear-to-send.
- `data`  out  `DATA_BITS`: FIFO head word.
- `valid`  out  1: FIFO non-empty.
- `ready`  in  1: consumer accepts the head word.
- `frame_error`  out  1: one-cycle pulse when the stop bit is sampled low.
- `parity_error`  out  1: one-cycle pulse on a parity mismatch.
- `overrun`  out  1: one-cycle pulse when a good word is dropped because the FIFO is full.

## Operation
- Input synchroniser: `rs232_txd` passes through a 2-flop synchroniser into `rxs`. All decisions use `rxs`.
- Frame bit index k: 0 is start, 1..`DATA_BITS` are data (LSB first), then parity (if enabled), then stop.
- Sample point for bit k: `timer` == `CLOCK_FREQ*(2k+1)/(2*BAUD_RATE)`, computed with integer arithmetic from the start edge. There is no cumulative rounding drift.
- `timer` width is `$clog2` of the stop-bit sample point plus 1.
- States:
  - IDLE: `timer`=0. A falling edge on `rxs` (previous 1, current 0) goes to RECV.
  - RECV: `timer` increments every cycle and each sample point captures one bit.
    - Start sample high: the edge was a glitch; go to IDLE with no push and no error.
  - At the stop sample:
    - Stop bit high and parity ok: push the word to the FIFO, go to IDLE.
    - Stop bit low: pulse `frame_error`, discard the word, go to BREAK.
    - Parity bad with stop bit high: pulse `parity_error`, discard the word, go to IDLE.
    - Parity bad with stop bit low: pulse both errors, go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE. A held-low line yields exactly one `frame_error`.
- FIFO:
  - A pop occurs on `valid && ready`.
  - A push is accepted if count < `DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the word is dropped and `overrun` pulses.
  - Pointers are `$clog2(DEPTH)+1` bits and wrap naturally.
- Flow control: `rs232_cts_n` is registered and equals (`DEPTH` − count_next ≤ `CTS_MARGIN`).
- A new start edge is accepted in the cycle immediately after returning to IDLE, so back-to-back frames work.

## Timing
- Reset values: `rs232_cts_n`=1, `valid`=0, `data`=0, all error pulses 0, state IDLE, FIFO empty.
- `rs232_cts_n` falls to 0 on the first clock edge after `reset_n` releases.
- Assertion of `reset_n` mid-frame aborts the frame and empties the FIFO immediately. No pulse is generated.
- Latency, stop-bit sample to `valid` on an empty FIFO: 1 cycle.
- Latency, line edge to `timer` start: 2 synchroniser cycles plus 1 edge-detect cycle. This offset is the same for every bit and is therefore harmless.
- `data` holds stable while `valid`=1 and `ready`=0.
- Pop followed by refill:
  - The next word appears the cycle after the pop.
  - `valid` stays high if the FIFO is still non-empty.
- Error pulses last exactly 1 cycle and are registered.

## Configuration
- `RS232_RX_PARITY_EN` defined:
  - A parity bit follows the data bits.
  - Expected parity is the XOR of the data bits, XOR `ODD_PARITY`.
- `RS232_RX_PARITY_EN` undefined:
  - No parity bit; the stop bit is at index `DATA_BITS`+1.
  - `parity_error` is tied to 0.
  - `ODD_PARITY` is ignored.

## Structure
- Package `rs232_pkg`:
  - State encoding (IDLE, RECV, BREAK).
  - Function `rs232_sample_point(clock_freq, baud_rate, k)`, shared with future transmitter revisions.
  - Function `rs232_frame_bits(data_bits, parity)`.
- Sub-module `rs232_fifo`:
  - Parametrised on width and depth, with a synchronous first-word-fall-through interface.
  - Exposes `count` for the CTS logic.

## Test plan
Bench settings: `CLOCK_FREQ`=1000000, `BAUD_RATE`=100000 (10 cycles/bit), `DEPTH`=4, `CTS_MARGIN`=1.
- Send 0xA5 with a good stop bit and `ready`=1 → one beat with `data`=0xA5; no error pulses.
- Send 0x00, 0xFF and 0x3C back-to-back with `ready`=0:
  - `valid` holds with `data`=0x00.
  - `rs232_cts_n` rises after the 3rd push.
  - Pops then return 0x00, 0xFF, 0x3C in order.
- Send 5 words with `ready`=0 → the 5th word produces `overrun`=1 for 1 cycle; the FIFO keeps the first 4.
- Send 0x55 with the stop bit low, then hold the line low for 30 cycles → one `frame_error` pulse; no push; the next good frame 0x12 is received.
- Parity build, even parity: send 0x07 with parity bit 0 → `parity_error` pulse and no push. Send it with parity bit 1 → `data`=0x07.
- Test these two cases:
  - Line glitch low for 3 cycles → no push and no error.
  - `reset_n` pulsed mid-frame → `valid`=0 and `rs232_cts_n`=1 during reset, and no spurious word afterwards.
